// File: rtl/altsyncram_model_pkg.sv
// Shared types and helpers for the altsyncram valid-propagation models.
// Used by both the a->b and b->a model directions.
package altsyncram_model_pkg;

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   typedef struct packed {
      logic av;
      logic ai;
      logic asg;
   } flags_t;

   function automatic flags_t derive_flags(input logic valid);
      flags_t f;
      f.av  = valid;
      f.ai  = ~valid;
      f.asg = f.av | f.ai;
      return f;
   endfunction

endpackage

// File: rtl/altsyncram_model_clear_fsm.sv
// Clear-sweep controller: after reset, walks the valid RAM writing 0 to one word
// per cycle, then parks in READY with the counter held at the last address.
module altsyncram_model_clear_fsm
   import altsyncram_model_pkg::*;
#(
   parameter int unsigned numwords = 256,
   parameter int unsigned widthad  = 8
) (
   input  logic               i_clock,
   input  logic               i_reset,
   output logic               o_clr_we,
   output logic [widthad-1:0] o_clr_addr,
   output logic               o_init_done
);

   localparam logic [widthad-1:0] LastAddr = widthad'(numwords - 1);

   state_e             r_state;
   state_e             w_state_d;
   logic [widthad-1:0] r_cnt;
   logic [widthad-1:0] w_cnt_d;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_cnt   <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_cnt_d   = r_cnt;
      o_clr_we  = 1'b0;
      case (r_state)
         CLEAR: begin
            o_clr_we = 1'b1;
            if (r_cnt == LastAddr) begin
               w_state_d = READY;
            end else begin
               w_cnt_d = r_cnt + 1'b1;
            end
         end
         READY:   ;
         default: w_state_d = CLEAR;
      endcase
   end

   assign o_clr_addr  = r_cnt;
   assign o_init_done = (r_state == READY);

endmodule

// File: rtl/altsyncram_b2a_model.sv
// Valid-bit model of an altsyncram wired b->a: channel b writes, channel a reads.
// Define ALTSYNCRAM_MODEL_BYPASS_EN to return new data on same-address read-during-write.
module altsyncram_b2a_model
   import altsyncram_model_pkg::*;
#(
   parameter int unsigned numwords = 256,
   parameter int unsigned widthad  = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               wren_b,
   input  logic [widthad-1:0] address_b,
   input  logic               valid_b,
   input  logic               rden_a,
   input  logic [widthad-1:0] address_a,
   output logic               valid_a,
   output logic               av_a,
   output logic               ai_a,
   output logic               assign_a,
   output logic               valid_q_a,
   output logic               av_q_a,
   output logic               ai_q_a,
   output logic               assign_q_a,
   output logic               init_done
);

   localparam logic [widthad:0] NumWordsW = (widthad + 1)'(numwords);

   logic               r_ram [numwords];
   logic               r_valid_a;
   logic               r_valid_q;
   flags_t             r_flags_q;
   flags_t             w_flags;
   logic               w_clr_we;
   logic [widthad-1:0] w_clr_addr;
   logic               w_b_in_range;
   logic               w_a_in_range;
   logic               w_user_we;
   logic               w_we;
   logic [widthad-1:0] w_waddr;
   logic               w_wdata;
   logic               w_rd_bit;

   altsyncram_model_clear_fsm #(
      .numwords (numwords),
      .widthad  (widthad)
   ) u_clear_fsm (
      .i_clock     (clock),
      .i_reset     (reset),
      .o_clr_we    (w_clr_we),
      .o_clr_addr  (w_clr_addr),
      .o_init_done (init_done)
   );

   assign w_b_in_range = ({1'b0, address_b} < NumWordsW);
   assign w_a_in_range = ({1'b0, address_a} < NumWordsW);
   assign w_user_we    = init_done & wren_b & w_b_in_range;

   // Sweep writes own the port while clearing; channel b is locked out.
   always_comb begin
      w_we    = 1'b0;
      w_waddr = address_b;
      w_wdata = valid_b;
      if (w_clr_we) begin
         w_we    = ~reset;
         w_waddr = w_clr_addr;
         w_wdata = 1'b0;
      end else begin
         w_we = w_user_we & ~reset;
      end
   end

   always_ff @(posedge clock) begin
      if (w_we) begin
         r_ram[w_waddr] <= w_wdata;
      end
   end

   always_comb begin
      w_rd_bit = 1'b0;
      if (w_a_in_range) begin
         w_rd_bit = r_ram[address_a];
`ifdef ALTSYNCRAM_MODEL_BYPASS_EN
         if (w_user_we && (address_b == address_a)) begin
            w_rd_bit = valid_b;
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset || !init_done) begin
         r_valid_a <= 1'b0;
      end else if (rden_a) begin
         r_valid_a <= w_rd_bit;
      end
   end

   assign w_flags = derive_flags(r_valid_a);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid_q <= 1'b0;
         r_flags_q <= derive_flags(1'b0);
      end else begin
         r_valid_q <= r_valid_a;
         r_flags_q <= w_flags;
      end
   end

   assign valid_a    = r_valid_a;
   assign av_a       = w_flags.av;
   assign ai_a       = w_flags.ai;
   assign assign_a   = w_flags.asg;
   assign valid_q_a  = r_valid_q;
   assign av_q_a     = r_flags_q.av;
   assign ai_q_a     = r_flags_q.ai;
   assign assign_q_a = r_flags_q.asg;

endmodule

// File: tb/tb_altsyncram_b2a_model.sv
// Self-checking bench for altsyncram_b2a_model: an 8-word instance for the main
// scenarios and a 6-word / 3-bit-address instance for out-of-range handling.
module tb_altsyncram_b2a_model;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // 8-word instance
   logic       reset = 1'b1, wren_b = 1'b0, valid_b = 1'b0, rden_a = 1'b0;
   logic [3:0] address_b = '0, address_a = '0;
   logic       valid_a, av_a, ai_a, assign_a;
   logic       valid_q_a, av_q_a, ai_q_a, assign_q_a, init_done;

   // 6-word instance
   logic       reset6 = 1'b1, wren6 = 1'b0, validb6 = 1'b0, rden6 = 1'b0;
   logic [2:0] addrb6 = '0, addra6 = '0;
   logic       valid6, av6, ai6, asg6, validq6, avq6, aiq6, asgq6, done6;

   logic mem [8];
   logic exp_q [$];

   altsyncram_b2a_model #(.numwords(8), .widthad(4)) dut (
      .clock(clk), .reset(reset), .wren_b(wren_b), .address_b(address_b),
      .valid_b(valid_b), .rden_a(rden_a), .address_a(address_a),
      .valid_a(valid_a), .av_a(av_a), .ai_a(ai_a), .assign_a(assign_a),
      .valid_q_a(valid_q_a), .av_q_a(av_q_a), .ai_q_a(ai_q_a),
      .assign_q_a(assign_q_a), .init_done(init_done)
   );

   altsyncram_b2a_model #(.numwords(6), .widthad(3)) dut_oor (
      .clock(clk), .reset(reset6), .wren_b(wren6), .address_b(addrb6),
      .valid_b(validb6), .rden_a(rden6), .address_a(addra6),
      .valid_a(valid6), .av_a(av6), .ai_a(ai6), .assign_a(asg6),
      .valid_q_a(validq6), .av_q_a(avq6), .ai_q_a(aiq6),
      .assign_q_a(asgq6), .init_done(done6)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_a(input int addr, input logic v);
      wren_b = 1'b1; address_b = 4'(addr); valid_b = v;
      tick();
      wren_b = 1'b0;
      mem[addr] = v;
   endtask

   // Waits for init_done with a bound and checks the sweep length.
   task automatic wait_sweep(input string name);
      int n = 0;
      while (!init_done && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 8) begin
         errors++;
         $display("FAIL %s: sweep took %0d cycles, required 8", name, n);
      end
      for (int i = 0; i < 8; i++) mem[i] = 1'b0;
   endtask

   // Pipelined read of all eight words, scoreboarded against the model.
   task automatic read_sweep(input string name);
      logic e, prev;
      prev = 1'b0;
      for (int a = 0; a < 8; a++) begin
         rden_a = 1'b1; address_a = 4'(a);
         exp_q.push_back(mem[a]);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (valid_a !== e || ai_a !== ~e) begin
            errors++;
            $display("FAIL %s addr %0d: valid_a=%b ai_a=%b, required %b/%b",
                     name, a, valid_a, ai_a, e, ~e);
         end
         if (a > 0) begin
            checks++;
            if (valid_q_a !== prev) begin
               errors++;
               $display("FAIL %s q addr %0d: valid_q_a=%b, required %b",
                        name, a - 1, valid_q_a, prev);
            end
         end
         prev = e;
      end
      rden_a = 1'b0;
      tick();
      checks++;
      if (valid_q_a !== prev) begin
         errors++;
         $display("FAIL %s q last: valid_q_a=%b, required %b", name, valid_q_a, prev);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      checks++;
      if ({valid_a, av_a, ai_a, assign_a} !== 4'b0011 ||
          {valid_q_a, av_q_a, ai_q_a, assign_q_a} !== 4'b0011 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: s1=%b s2=%b done=%b, required 0011 0011 0",
                  {valid_a, av_a, ai_a, assign_a},
                  {valid_q_a, av_q_a, ai_q_a, assign_q_a}, init_done);
      end
      reset = 1'b0;
      wait_sweep("reset_sweep");
      read_sweep("reset_clear_read");
   endtask

   task automatic test_write_read();
      write_a(5, 1'b1);
      rden_a = 1'b1; address_a = 4'd5;
      tick();
      rden_a = 1'b0;
      checks++;
      if (valid_a !== 1'b1) begin
         errors++;
         $display("FAIL wr5_stage1: valid_a=%b, required 1", valid_a);
      end
      tick();
      checks++;
      if ({valid_q_a, av_q_a, ai_q_a, assign_q_a} !== 4'b1101) begin
         errors++;
         $display("FAIL wr5_stage2: q=%b, required 1101",
                  {valid_q_a, av_q_a, ai_q_a, assign_q_a});
      end
      for (int a = 0; a < 8; a++) write_a(a, 1'($urandom_range(0, 1)));
      read_sweep("random_pattern");
   endtask

   task automatic test_rdw();
      logic e;
`ifdef ALTSYNCRAM_MODEL_BYPASS_EN
      e = 1'b1;
`else
      e = 1'b0;
`endif
      write_a(3, 1'b0);
      wren_b = 1'b1; address_b = 4'd3; valid_b = 1'b1;
      rden_a = 1'b1; address_a = 4'd3;
      tick();
      wren_b = 1'b0; rden_a = 1'b0;
      mem[3] = 1'b1;
      checks++;
      if (valid_a !== e) begin
         errors++;
         $display("FAIL read_during_write: valid_a=%b, required %b", valid_a, e);
      end
      read_sweep("after_rdw");
   endtask

   task automatic test_mid_sweep();
      write_a(7, 1'b1);
      rden_a = 1'b1; address_a = 4'd7;
      tick();
      // Reset wins over a concurrent read and write.
      reset = 1'b1; wren_b = 1'b1; address_b = 4'd7; valid_b = 1'b1;
      tick();
      checks++;
      if ({valid_a, ai_a, valid_q_a, ai_q_a, assign_q_a, init_done} !== 6'b010110) begin
         errors++;
         $display("FAIL reset_over_rw: got %b, required 010110",
                  {valid_a, ai_a, valid_q_a, ai_q_a, assign_q_a, init_done});
      end
      reset = 1'b0; wren_b = 1'b0; rden_a = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      // Counter is at 4: write must be dropped, read must be forced to 0.
      wren_b = 1'b1; address_b = 4'd2; valid_b = 1'b1;
      rden_a = 1'b1; address_a = 4'd7;
      tick();
      wren_b = 1'b0; rden_a = 1'b0;
      checks++;
      if (valid_a !== 1'b0 || init_done !== 1'b0) begin
         errors++;
         $display("FAIL clear_read_forced: valid_a=%b done=%b, required 0 0",
                  valid_a, init_done);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (init_done !== 1'b1) begin
         errors++;
         $display("FAIL sweep_len_after_reset: init_done=%b, required 1", init_done);
      end
      for (int i = 0; i < 8; i++) mem[i] = 1'b0;
      read_sweep("dropped_clear_write");
      write_a(6, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      wait_sweep("reset_at_count4");
      read_sweep("after_second_sweep");
   endtask

   task automatic test_rden_hold();
      write_a(1, 1'b1);
      write_a(0, 1'b0);
      rden_a = 1'b1; address_a = 4'd1;
      tick();
      rden_a = 1'b0; address_a = 4'd0;
      tick();
      checks++;
      if (valid_a !== 1'b1 || valid_q_a !== 1'b1) begin
         errors++;
         $display("FAIL rden_hold: valid_a=%b valid_q_a=%b, required 1 1", valid_a, valid_q_a);
      end
      rden_a = 1'b1;
      tick();
      rden_a = 1'b0;
      checks++;
      if (valid_a !== 1'b0 || valid_q_a !== 1'b1) begin
         errors++;
         $display("FAIL rden_resume: valid_a=%b valid_q_a=%b, required 0 1", valid_a, valid_q_a);
      end
      tick();
      checks++;
      if (valid_q_a !== 1'b0 || ai_q_a !== 1'b1) begin
         errors++;
         $display("FAIL q_follow: valid_q_a=%b ai_q_a=%b, required 0 1", valid_q_a, ai_q_a);
      end
   endtask

   task automatic test_out_of_range();
      logic pat [6];
      logic e;
      int   n = 0;
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      reset6 = 1'b1;
      tick();
      reset6 = 1'b0;
      while (!done6 && n < 30) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL oor_sweep: %0d cycles, required 6", n);
      end
      for (int a = 0; a < 6; a++) begin
         wren6 = 1'b1; addrb6 = 3'(a); validb6 = pat[a];
         tick();
      end
      for (int a = 6; a < 8; a++) begin
         addrb6 = 3'(a); validb6 = 1'b1;
         tick();
      end
      wren6 = 1'b0;
      for (int a = 7; a >= 0; a--) begin
         rden6 = 1'b1; addra6 = 3'(a);
         exp_q.push_back(a < 6 ? pat[a] : 1'b0);
         tick();
         e = exp_q.pop_front();
         checks++;
         if (valid6 !== e) begin
            errors++;
            $display("FAIL oor_read addr %0d: valid_a=%b, required %b", a, valid6, e);
         end
      end
      rden6 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_rdw();
      test_mid_sweep();
      test_rden_hold();
      test_out_of_range();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
